dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache controller that answers the loads and stores held in the EX/MEM pipeline register, sitting between that register and the off-chip data memory. It drives the stall line that freezes EX/MEM and every upstream stage until the access completes. It owns the tag, valid, dirty and data arrays, and runs a miss state machine against a 256-bit request/acknowledge memory port.

---
 rtl/dcache_ctrl.sv | 139 +++++++++++++
 tb/tb_dcache_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache between the EX/MEM register
// and a 256-bit request/acknowledge memory port; misses run a small FSM and stall the pipe.
module dcache_ctrl #(
  parameter int SETS   = 16,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic              mem_ack_i
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WORDS  = LINE_W / 32;
  localparam int WSEL_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, WRITEBACK, TURN, ALLOCATE} state_t;

  state_t             state_reg;
  logic [SETS-1:0]    valid_reg;
  logic [SETS-1:0]    dirty_reg;
  logic [TAG_W-1:0]   miss_tag_reg;
  logic [IDX_W-1:0]   miss_idx_reg;

  logic [TAG_W-1:0]   tag_array  [SETS];
  logic [LINE_W-1:0]  data_array [SETS];

  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   req_idx;
  logic [WSEL_W-1:0]  req_word;
  logic               request;
  logic               hit;
  logic               in_idle;
  logic [LINE_W-1:0]  sel_line;
  logic [31:0]        line_words [WORDS];
  logic               unused_addr_bits;

  assign req_tag          = cpu_addr_i[31 -: TAG_W];
  assign req_idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign req_word         = cpu_addr_i[2 +: WSEL_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign request  = cpu_MemRead_i | cpu_MemWrite_i;
  assign in_idle  = (state_reg == IDLE);
  assign hit      = valid_reg[req_idx] & (tag_array[req_idx] == req_tag);
  assign sel_line = data_array[req_idx];

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
      assign line_words[gi] = sel_line[gi*32 +: 32];
    end
  endgenerate

  // Reset forces both CPU-facing outputs low even while a request is still held.
  assign cpu_stall_o = ~rst_i & (~in_idle | (request & ~hit));
  assign cpu_data_o  = (~rst_i & in_idle & cpu_MemRead_i & ~cpu_MemWrite_i & hit)
                       ? line_words[req_word] : 32'd0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      valid_reg    <= '0;
      dirty_reg    <= '0;
      miss_tag_reg <= '0;
      miss_idx_reg <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= 32'd0;
      mem_data_o   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (request && hit) begin
            if (cpu_MemWrite_i) dirty_reg[req_idx] <= 1'b1;
          end else if (request) begin
            miss_tag_reg <= req_tag;
            miss_idx_reg <= req_idx;
            mem_enable_o <= 1'b1;
            if (valid_reg[req_idx] && dirty_reg[req_idx]) begin
              state_reg   <= WRITEBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {tag_array[req_idx], req_idx, {OFF_W{1'b0}}};
              mem_data_o  <= data_array[req_idx];
            end else begin
              state_reg   <= ALLOCATE;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {req_tag, req_idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state_reg    <= TURN;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
          end
        end
        TURN: begin
          state_reg    <= ALLOCATE;
          mem_enable_o <= 1'b1;
          mem_write_o  <= 1'b0;
          mem_addr_o   <= {miss_tag_reg, miss_idx_reg, {OFF_W{1'b0}}};
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state_reg               <= IDLE;
            mem_enable_o            <= 1'b0;
            valid_reg[miss_idx_reg] <= 1'b1;
            dirty_reg[miss_idx_reg] <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk_i) begin
    if (state_reg == ALLOCATE && mem_ack_i) begin
      data_array[miss_idx_reg] <= mem_data_i;
      tag_array[miss_idx_reg]  <= miss_tag_reg;
    end else if (in_idle && cpu_MemWrite_i && hit) begin
      data_array[req_idx][{req_word, 5'b0} +: 32] <= cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed scenarios then random loads/stores against a
// set-by-set cache model with a sparse backing memory that also plays the memory port.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic         mem_ack_i;

  dcache_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_ack_i      (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  typedef struct {
    bit           w;
    logic [31:0]  addr;
    logic [255:0] data;
    int           lat;
  } mreq_t;

  bit           m_valid [16];
  bit           m_dirty [16];
  logic [22:0]  m_tag   [16];
  logic [255:0] m_data  [16];
  logic [255:0] mem_model [logic [31:0]];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] get_line(input logic [31:0] a);
    logic [255:0] l;
    if (!mem_model.exists(a)) begin
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      mem_model[a] = l;
    end
    return mem_model[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One complete CPU access; the bench answers memory requests after lat_wb / lat_rf cycles.
  task automatic do_access(input logic [31:0] addr, input bit rd, input bit wr,
                           input logic [31:0] wdata, input int lat_wb, input int lat_rf);
    logic [3:0]   idx;
    logic [22:0]  tg;
    logic [31:0]  laddr, vaddr, exp_rd;
    int           w, exp_stall, stalls, cur, rcnt;
    bit           hit, prev_en, done;
    mreq_t        q[$];
    mreq_t        r;
    idx   = addr[8:5];
    tg    = addr[31:9];
    w     = int'(addr[4:2]);
    laddr = {addr[31:5], 5'b0};
    hit   = m_valid[idx] && (m_tag[idx] == tg);
    exp_stall = 0;
    if (!hit) begin
      exp_stall = 1 + lat_rf;
      if (m_valid[idx] && m_dirty[idx]) begin
        vaddr = {m_tag[idx], idx, 5'b0};
        r.w = 1'b1; r.addr = vaddr; r.data = m_data[idx]; r.lat = lat_wb;
        q.push_back(r);
        mem_model[vaddr] = m_data[idx];
        exp_stall += 1 + lat_wb;
      end
      r.w = 1'b0; r.addr = laddr; r.data = get_line(laddr); r.lat = lat_rf;
      q.push_back(r);
      m_data[idx]  = r.data;
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    if (wr) begin
      m_data[idx][w*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
      exp_rd = 32'd0;
    end else begin
      exp_rd = m_data[idx][w*32 +: 32];
    end

    cpu_addr_i     = addr;
    cpu_data_i     = wdata;
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    stalls = 0; cur = -1; rcnt = 0; prev_en = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk_i);
      if (mem_enable_o) begin
        if (!prev_en) begin
          cur++;
          rcnt = 0;
        end
        rcnt++;
        if (cur < q.size()) begin
          chk("mem_write", mem_write_o, q[cur].w);
          chk("mem_addr", mem_addr_o, q[cur].addr);
          if (q[cur].w) chk("wb_data", mem_data_o, q[cur].data);
          if (rcnt == q[cur].lat) begin
            mem_ack_i = 1'b1;
            if (!q[cur].w) mem_data_i = q[cur].data;
          end
        end else begin
          chk("extra_mem_req", mem_enable_o, 1'b0);
        end
      end
      prev_en = mem_enable_o;
      if (cpu_stall_o) begin
        stalls++;
      end else begin
        done = 1'b1;
        chk("stall_cycles", stalls, exp_stall);
        chk("cpu_data", cpu_data_o, exp_rd);
        chk("mem_req_count", cur + 1, q.size());
      end
      @(posedge clk_i);
      #1;
      mem_ack_i  = 1'b0;
      mem_data_i = {8{$urandom}};
    end
    if (!done) chk("stall_timeout", cpu_stall_o, 1'b0);
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    @(negedge clk_i);
    chk("idle_stall", cpu_stall_o, 1'b0);
    chk("idle_data", cpu_data_o, 32'd0);
    chk("idle_enable", mem_enable_o, 1'b0);
    $display("txn %0d addr=%h rd=%0d wr=%0d hit=%0d stall=%0d data=%h",
             txn, addr, rd, wr, hit, stalls, exp_rd);
    txn++;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [255:0] l;
    logic [31:0]  a;
    bit           rd, wr;

    model_reset();
    rst_i          = 1'b1;
    cpu_addr_i     = 32'h24;
    cpu_data_i     = 32'd0;
    cpu_MemRead_i  = 1'b1;
    cpu_MemWrite_i = 1'b0;
    mem_data_i     = '0;
    mem_ack_i      = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_data", cpu_data_o, 32'd0);
    chk("rst_enable", mem_enable_o, 1'b0);
    chk("rst_write", mem_write_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_wbdata", mem_data_o, 256'd0);
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    l[63:32] = 32'hDEADBEEF;
    mem_model[32'h20] = l;
    do_access(32'h24, 1, 0, 32'd0, 0, 10);        // cold miss, stall 11
    do_access(32'h24, 1, 0, 32'd0, 0, 10);        // hit
    do_access(32'h24, 0, 1, 32'h12345678, 0, 10); // store hit
    do_access(32'h24, 1, 0, 32'd0, 0, 10);
    do_access(32'h224, 1, 0, 32'd0, 10, 10);      // dirty miss, stall 22
    chk("wb_word1", mem_model[32'h20][63:32], 32'h12345678);
    do_access(32'h444, 0, 1, 32'h55AA55AA, 0, 3); // store miss to clean line
    do_access(32'h444, 1, 0, 32'd0, 0, 3);
    do_access(32'h044, 1, 0, 32'd0, 2, 3);        // evicts the merged line

    // Reset in the middle of a refill
    cpu_addr_i    = 32'hE4;
    cpu_MemRead_i = 1'b1;
    @(negedge clk_i);
    chk("rm_miss_stall", cpu_stall_o, 1'b1);
    repeat (2) begin
      @(negedge clk_i);
      chk("rm_alloc_enable", mem_enable_o, 1'b1);
    end
    rst_i = 1'b1;
    #1;
    chk("rm_enable_drop", mem_enable_o, 1'b0);
    chk("rm_stall_drop", cpu_stall_o, 1'b0);
    @(posedge clk_i);
    #1;
    cpu_MemRead_i = 1'b0;
    rst_i = 1'b0;
    model_reset();
    $display("txn %0d reset during refill", txn);
    txn++;
    @(posedge clk_i);
    #1;
    do_access(32'hE4, 1, 0, 32'd0, 0, 3);         // misses again
    do_access(32'h24, 1, 0, 32'd0, 0, 2);         // reset invalidated everything

    for (int n = 0; n < 80; n++) begin
      a  = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) |
           ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      wr = ($urandom_range(0, 2) == 0);
      rd = !wr || ($urandom_range(0, 3) == 0);
      do_access(a, rd, wr, $urandom, $urandom_range(1, 5), $urandom_range(1, 5));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
